// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM states, line levels, frame length.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Number of CE ticks a frame occupies on the line after leaving PEND.
    function automatic int unsigned frame_len(input int unsigned width,
                                              input int unsigned stop_bits,
                                              input bit          parity_en);
        return 1 + width + (parity_en ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/serial_tx_shift_reg.sv
// CE-gated load/shift register for serial_tx; parity of the loaded word is
// kept only when SERIAL_TX_PARITY_EN is defined.
module tx_shift_reg
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ce_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit0_o
`ifdef SERIAL_TX_PARITY_EN
    ,
    output logic             parity_o
`endif
);

    logic [WIDTH-1:0] shift_q, shift_d;

    // Loading is independent of CE so a word can be accepted between ticks.
    always_comb begin
        shift_d = shift_q;
        if (load_i) begin
            shift_d = data_i;
        end else if (ce_i && shift_i) begin
            shift_d = shift_q >> 1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign bit0_o = shift_q[0];

`ifdef SERIAL_TX_PARITY_EN
    logic parity_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            parity_q <= 1'b0;
        end else if (load_i) begin
            parity_q <= ^data_i;
        end
    end

    assign parity_o = parity_q;
`endif

endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: start bit, WIDTH data bits LSB first, optional even parity
// (SERIAL_TX_PARITY_EN), STOP_BITS stop bits; one bit per CE tick.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             VALID_IN,
    output logic             READY_OUT,
    output logic             TX_OUT,
    output logic             BUSY
);

    localparam int unsigned CNT_W     = $clog2(WIDTH + 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_e             state_q, state_d;
    logic               tx_q, tx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stop_q, stop_d;
    logic               load, shift, bit0;
`ifdef SERIAL_TX_PARITY_EN
    logic               parity;
`endif

    tx_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .CLK     (CLK),
        .RESET   (RESET),
        .ce_i    (CE),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (DATA_IN),
        .bit0_o  (bit0)
`ifdef SERIAL_TX_PARITY_EN
        ,
        .parity_o(parity)
`endif
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            tx_q    <= IDLE_LEVEL;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
        end
    end

    // cnt_q counts data bits already on the line; START emits the first one.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = IDLE_LEVEL;
                if (VALID_IN) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (CE) begin
                    state_d = ST_START;
                    tx_d    = START_LEVEL;
                end
            end
            ST_START: begin
                shift = 1'b1;
                if (CE) begin
                    state_d = ST_DATA;
                    tx_d    = bit0;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    if (CE) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = parity;
`else
                        state_d = ST_STOP;
                        tx_d    = IDLE_LEVEL;
`endif
                    end
                end else begin
                    shift = 1'b1;
                    if (CE) begin
                        tx_d  = bit0;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (CE) begin
                    state_d = ST_STOP;
                    tx_d    = IDLE_LEVEL;
                end
            end
`endif
            ST_STOP: begin
                if (CE) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase
    end

    assign TX_OUT    = tx_q;
    assign READY_OUT = (state_q == ST_IDLE);
    assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: expected frames queued at acceptance, a line
// monitor rebuilds frames tick by tick and compares.
`timescale 1ns/1ps
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b1;
    logic [7:0] d0  = '0;
    logic [7:0] d1  = '0;
    logic       v0  = 1'b0;
    logic       v1  = 1'b0;
    logic       r0, r1, t0, t1, b0, b1;

    int checks = 0;
    int errors = 0;
    int ce_per = 1;
    int ce_div = 0;
    int cyc    = 0;
    logic ce_e  = 1'b1;
    logic rst_e = 1'b1;

    logic [19:0] q0[$];
    logic [19:0] q1[$];

    logic        act[2];
    int          mn[2];
    logic [19:0] mb[2];
    logic        ml[2];
    int          st_prev[2];
    int          st_last[2];
    logic        txv;
    logic [19:0] expf;

    serial_tx #(.WIDTH(8), .STOP_BITS(1)) dut0 (
        .CLK(clk), .RESET(rst), .CE(ce), .DATA_IN(d0), .VALID_IN(v0),
        .READY_OUT(r0), .TX_OUT(t0), .BUSY(b0)
    );

    serial_tx #(.WIDTH(8), .STOP_BITS(2)) dut1 (
        .CLK(clk), .RESET(rst), .CE(ce), .DATA_IN(d1), .VALID_IN(v1),
        .READY_OUT(r1), .TX_OUT(t1), .BUSY(b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ce_e  <= ce;
        rst_e <= rst;
    end

    initial begin
        forever begin
            @(negedge clk);
            ce_div = ce_div + 1;
            ce = (ce_per <= 1) || (ce_div % ce_per == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    // Frame in line order, bit 0 = start bit; parity value is hand-supplied.
    function automatic logic [19:0] frm(input logic [7:0] d, input logic par, input int stops);
        logic [19:0] f;
        int k;
        f      = '0;
        f[8:1] = d;
        k      = 9;
        if (P == 1) begin
            f[k] = par;
            k++;
        end
        for (int s = 0; s < stops; s++) begin
            f[k] = 1'b1;
            k++;
        end
        return f;
    endfunction

    function automatic int flen(input int i);
        return (i == 0) ? 10 + P : 11 + P;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; mn[i] = 0; mb[i] = '0; ml[i] = 1'b1;
            st_prev[i] = 0; st_last[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                txv = (i == 0) ? t0 : t1;
                if (rst_e) begin
                    act[i] = 1'b0;
                end else if (!act[i]) begin
                    if (txv == 1'b0) begin
                        chk($sformatf("start_on_tick%0d", i), ce_e, 1);
                        act[i] = 1'b1; mn[i] = 1; mb[i] = '0; ml[i] = 1'b0;
                        st_prev[i] = st_last[i];
                        st_last[i] = cyc;
                    end
                end else if (ce_e) begin
                    mb[i][mn[i]] = txv;
                    ml[i] = txv;
                    mn[i]++;
                    if (mn[i] == flen(i)) begin
                        act[i] = 1'b0;
                        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame%0d: got %0h expected none", i, mb[i]);
                        end else begin
                            expf = (i == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("frame%0d", i), mb[i], expf);
                        end
                    end
                end else begin
                    chk($sformatf("hold_between_ticks%0d", i), txv, ml[i]);
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d, input logic [19:0] f, input bit push);
        int w;
        w = 0;
        while (((i == 0) ? r0 : r1) !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout%0d: got busy expected ready", i);
        end
        if (i == 0) begin
            d0 = d; v0 = 1'b1;
            if (push) q0.push_back(f);
        end else begin
            d1 = d; v1 = 1'b1;
            if (push) q1.push_back(f);
        end
        @(negedge clk);
        if (i == 0) v0 = 1'b0; else v1 = 1'b0;
        chk($sformatf("accept_ready_low%0d", i), (i == 0) ? r0 : r1, 0);
        chk($sformatf("accept_busy%0d", i), (i == 0) ? b0 : b1, 1);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx0", t0, 1);  chk("reset_ready0", r0, 1); chk("reset_busy0", b0, 0);
        chk("reset_tx1", t1, 1);  chk("reset_ready1", r1, 1); chk("reset_busy1", b1, 0);

        // CE always high: 0xA5, ready returns at the final stop tick
        ce_per = 1;
        send(0, 8'hA5, frm(8'hA5, 1'b0, 1), 1'b1);
        repeat (10 + P) @(negedge clk);
        chk("ready_low_in_stop", r0, 0);
        @(negedge clk);
        chk("ready_at_final_stop_tick", r0, 1);

        // CE every 4th cycle: 0x01, each bit held 4 CLK
        ce_per = 4;
        send(0, 8'h01, frm(8'h01, 1'b1, 1), 1'b1);
        c = 0;
        while (t0 !== 1'b0 && c < 50) begin @(negedge clk); c++; end
        chk("start_seen_ce4", t0, 0);
        c = 0;
        while (r0 !== 1'b1 && c < 200) begin @(negedge clk); c++; end
        chk("frame_clk_len_ce4", c, 4 * (10 + P));

        // VALID held with changing data: only first word, second after IDLE
        ce_per = 1;
        @(negedge clk);
        d0 = 8'h3C; v0 = 1'b1; q0.push_back(frm(8'h3C, 1'b0, 1));
        @(negedge clk);
        c = 1;
        while (r0 !== 1'b1 && c < 60) begin
            d0 = d0 + 8'h17;
            @(negedge clk);
            c++;
        end
        chk("held_valid_next_accept_cycle", c, 12 + P);
        d0 = 8'h5A; q0.push_back(frm(8'h5A, 1'b0, 1));
        @(negedge clk);
        v0 = 1'b0;
        chk("held_valid_second_accept", r0, 0);

        // Parity values
        send(0, 8'h07, frm(8'h07, 1'b1, 1), 1'b1);
        send(0, 8'h03, frm(8'h03, 1'b0, 1), 1'b1);

        // Two stop bits, back-to-back frames
        send(1, 8'hFF, frm(8'hFF, 1'b0, 2), 1'b1);
        send(1, 8'h00, frm(8'h00, 1'b0, 2), 1'b1);
        c = 0;
        while (r1 !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        chk("b2b_start_spacing", st_last[1] - st_prev[1], 13 + P);

        // Reset mid-frame: aborted, not resumed
        send(0, 8'h55, '0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_tx", t0, 1); chk("midreset_ready", r0, 1); chk("midreset_busy", b0, 0);
        repeat (25) begin
            @(negedge clk);
            chk("no_resume", t0, 1);
        end

        send(0, 8'hC3, frm(8'hC3, 1'b0, 1), 1'b1);
        c = 0;
        while (r0 !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out frame transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it onto a single line as start bit, data bits LSB first, optional parity bit and stop bit(s). Bit timing comes entirely from the CE bit-tick, so it shares CE-gated, synchronous-reset registers with the rest of the datapath. It is the sending end of the serial link whose receiving end captures one bit per CE tick.

## Interface

- WIDTH, 8, data bits per frame (1..16)
- STOP_BITS, 1, stop bits per frame (1 or 2)
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high; clock CLK
- CE  input  1  bit tick; one serial bit period elapses per CLK edge with CE=1
- DATA_IN  input  WIDTH  word to send, sampled at handshake
- VALID_IN  input  1  DATA_IN valid
- READY_OUT  output  1  transmitter can accept a word
- TX_OUT  output  1  serial line, idle level 1
- BUSY  output  1  frame in progress (any state except IDLE)

## Operation

- States: IDLE, PEND, START, DATA, PARITY (only with PARITY_EN), STOP.
- IDLE: READY_OUT=1, TX_OUT=1. VALID_IN=1 at a CLK edge → word latched into shift register, bit counter cleared, go PEND. CE not required for acceptance.
- PEND: TX_OUT=1, READY_OUT=0; wait for CE edge → START, TX_OUT<=0.
- START: next CE edge → DATA, TX_OUT<=shift[0], shift right.
- DATA: each CE edge emits next bit; after WIDTH bits emitted, next CE edge → PARITY (TX_OUT<=parity) or STOP (TX_OUT<=1).
- PARITY: CE edge → STOP, TX_OUT<=1.
- STOP: held STOP_BITS CE periods; final CE edge → IDLE.
- Parity: even, XOR of the latched word, computed at acceptance.
- Edges with CE=0 change nothing except handshake in IDLE.
- DATA_IN/VALID_IN ignored outside IDLE; no queueing.
- Every non-IDLE bit lasts exactly one CE interval; line never glitches between ticks.

## Timing

- Reset values: TX_OUT=1, READY_OUT=1, BUSY=0, state IDLE, shift register and counter 0.
- RESET has priority over CE and VALID_IN; reset mid-frame aborts, TX_OUT=1 on the following cycle, partial frame not resumed.
- All outputs registered; no combinational path from inputs to outputs.
- Acceptance → READY_OUT=0, BUSY=1 on next cycle.
- Start bit begins at the first CE edge after acceptance (CE coincident with the accept edge is not counted).
- Frame length: 1 + WIDTH + P + STOP_BITS CE ticks after PEND, P=1 with PARITY_EN else 0.
- CE held continuously high: one bit per CLK; IDLE reached at the last stop-bit tick, READY_OUT=1 same cycle, so next accept can occur one CLK later.

## Configuration

- SERIAL_TX_PARITY_EN defined: PARITY state present, even parity bit between last data bit and first stop bit.
- Undefined: PARITY state and parity logic removed; DATA goes directly to STOP.

## Structure

- Shared package serial_pkg: state enumeration, IDLE_LEVEL=1'b1, START_LEVEL=1'b0, frame-length function of WIDTH/STOP_BITS/parity.
- Sub-module tx_shift_reg: WIDTH-bit CE-gated load/shift register with synchronous reset, exposes bit 0 and parity of loaded word. FSM and bit/stop counters stay in serial_tx.

## Test plan

- Reset: RESET high 3 cycles mid-frame → TX_OUT=1, READY_OUT=1, BUSY=0 on cycle after RESET; no resumed bits.
- WIDTH=8, CE always 1, send 0xA5 with parity → TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; READY_OUT high again at final stop tick.
- CE every 4th cycle, send 0x01, no parity → each bit held 4 CLK; sequence 0,1,0,0,0,0,0,0,0,1; frame 40 CLK.
- VALID_IN held high with changing DATA_IN during frame → only first word transmitted; second accepted only after IDLE.
- STOP_BITS=2, back-to-back 0xFF then 0x00 with CE=1 → two 1-level stop bits, then start bit of second frame two CLK after last stop bit.
- Parity: send 0x07 → parity bit 1; send 0x03 → parity bit 0.
